// File: rtl/regfile_wb_queue_if.sv
// Producer-side writeback handshake bundle: producer A (ALU) and producer B (load/multi-cycle).
interface regfile_wb_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the single register-file write port from two producers.
// Define WB_QUEUE_BYPASS_EN to forward the youngest pending value to decode.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_queue_if.slave      prod,
  input  logic                   wb_hold,
  output logic                   wb_en,
  output logic [AW-1:0]          wb_addr,
  output logic [DW-1:0]          wb_data,
  input  logic [AW-1:0]          rd_addr_0,
  input  logic [AW-1:0]          rd_addr_1,
  output logic                   pend_0,
  output logic                   pend_1,
  output logic                   byp_hit_0,
  output logic                   byp_hit_1,
  output logic [DW-1:0]          byp_data_0,
  output logic [DW-1:0]          byp_data_1,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic a_fire, b_fire, a_store, b_store, pop;

  // Ready depends only on the registered count; a drain in the same cycle is not credited.
  assign prod.a_ready = (count < CW'(DEPTH));
  assign a_fire       = prod.a_valid & prod.a_ready;
  assign prod.b_ready = ((count + CW'(a_fire)) < CW'(DEPTH));
  assign b_fire       = prod.b_valid & prod.b_ready;

  // Register 0 is hardwired zero, so those writes are accepted and dropped.
  assign a_store = a_fire & (prod.a_addr != '0);
  assign b_store = b_fire & (prod.b_addr != '0);
  assign pop     = ~wb_hold & (count != '0);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (a_store) begin
      mem_addr[tail] <= prod.a_addr;
      mem_data[tail] <= prod.a_data;
    end
    if (b_store) begin
      mem_addr[tail + PW'(a_store)] <= prod.b_addr;
      mem_data[tail + PW'(a_store)] <= prod.b_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      tail  <= tail + PW'(a_store) + PW'(b_store);
      head  <= head + PW'(pop);
      count <= count + CW'(a_store) + CW'(b_store) - CW'(pop);
      wb_en <= pop;
      if (pop) begin
        wb_addr <= mem_addr[head];
        wb_data <= mem_data[head];
      end
    end
  end

  logic [AW-1:0] rd_addr [2];
  logic [1:0]    pend_v;

  assign rd_addr[0] = rd_addr_0;
  assign rd_addr[1] = rd_addr_1;

  always_comb begin
    pend_v = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd_addr[p] != '0) begin
        if (wb_en && (wb_addr == rd_addr[p])) pend_v[p] = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
          if ((k < int'(count)) && (mem_addr[head + PW'(k)] == rd_addr[p])) pend_v[p] = 1'b1;
        end
      end
    end
  end

  assign pend_0 = pend_v[0];
  assign pend_1 = pend_v[1];

`ifdef WB_QUEUE_BYPASS_EN
  logic [DW-1:0] fwd_data [2];

  // Scan oldest to youngest (wb stage, then head..tail) so the last match wins.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_data[p] = '0;
      if (rd_addr[p] != '0) begin
        if (wb_en && (wb_addr == rd_addr[p])) fwd_data[p] = wb_data;
        for (int k = 0; k < DEPTH; k++) begin
          if ((k < int'(count)) && (mem_addr[head + PW'(k)] == rd_addr[p]))
            fwd_data[p] = mem_data[head + PW'(k)];
        end
      end
    end
  end

  assign byp_hit_0  = pend_v[0];
  assign byp_hit_1  = pend_v[1];
  assign byp_data_0 = fwd_data[0];
  assign byp_data_1 = fwd_data[1];
`else
  assign byp_hit_0  = 1'b0;
  assign byp_hit_1  = 1'b0;
  assign byp_data_0 = '0;
  assign byp_data_1 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue (DEPTH=4, AW=5, DW=32).
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_hold;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rd_addr_0, rd_addr_1;
  logic          pend_0, pend_1;
  logic          byp_hit_0, byp_hit_1;
  logic [DW-1:0] byp_data_0, byp_data_1;
  logic [2:0]    count;
  logic          full, empty;

  int n_chk = 0;
  int n_err = 0;

  regfile_wb_queue_if #(.AW(AW), .DW(DW)) prod ();

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .prod(prod), .wb_hold(wb_hold),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .pend_0(pend_0), .pend_1(pend_1),
    .byp_hit_0(byp_hit_0), .byp_hit_1(byp_hit_1),
    .byp_data_0(byp_data_0), .byp_data_1(byp_data_1),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    prod.a_valid = v; prod.a_addr = ad; prod.a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    prod.b_valid = v; prod.b_addr = ad; prod.b_data = d;
  endtask

  int pulses;

  initial begin
    rst = 1'b1; wb_hold = 1'b0; rd_addr_0 = '0; rd_addr_1 = '0;
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    tick(); tick();
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    rst = 1'b0;

    // single A write, latency to wb port
    drive_a(1'b1, 5'd3, 32'hDEADBEEF);
    check("t1_a_ready", prod.a_ready, 1);
    tick();
    drive_a(1'b0, '0, '0);
    check("t1_count_e1", count, 1);
    check("t1_wb_en_e1", wb_en, 0);
    tick();
    check("t1_wb_en_e2", wb_en, 1);
    check("t1_wb_addr", wb_addr, 3);
    check("t1_wb_data", wb_data, 32'hDEADBEEF);
    check("t1_empty_e2", empty, 1);
    tick();
    check("t1_wb_en_e3", wb_en, 0);

    // A and B in the same cycle; A is older
    drive_a(1'b1, 5'd5, 32'h11);
    drive_b(1'b1, 5'd6, 32'h22);
    check("t2_a_ready", prod.a_ready, 1);
    check("t2_b_ready", prod.b_ready, 1);
    tick();
    drive_a(1'b0, '0, '0); drive_b(1'b0, '0, '0);
    check("t2_count", count, 2);
    tick();
    check("t2_wb0_en", wb_en, 1);
    check("t2_wb0_addr", wb_addr, 5);
    check("t2_wb0_data", wb_data, 32'h11);
    tick();
    check("t2_wb1_en", wb_en, 1);
    check("t2_wb1_addr", wb_addr, 6);
    check("t2_wb1_data", wb_data, 32'h22);
    tick();
    check("t2_idle", wb_en, 0);

    // fill under hold; B blocked when A takes the last slot
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 5'(8 + i), 32'h100 + i);
      tick();
    end
    check("t3_count3", count, 3);
    drive_a(1'b1, 5'd11, 32'h103);
    drive_b(1'b1, 5'd20, 32'h999);
    check("t3_a_ready_c3", prod.a_ready, 1);
    check("t3_b_ready_c3", prod.b_ready, 0);
    tick();
    check("t3_full", full, 1);
    check("t3_count4", count, 4);
    check("t3_a_ready_full", prod.a_ready, 0);
    check("t3_b_ready_full", prod.b_ready, 0);
    check("t3_no_wb_hold", wb_en, 0);
    drive_a(1'b0, '0, '0); drive_b(1'b0, '0, '0);
    rd_addr_0 = 5'd10;
    #1 check("t3_pend_hit", pend_0, 1);
    rd_addr_0 = 5'd20;
    #1 check("t3_pend_rejected_b", pend_0, 0);
    wb_hold = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("t3_drain_en", wb_en, 1);
      check("t3_drain_addr", wb_addr, 8 + i);
      check("t3_drain_data", wb_data, 32'h100 + i);
    end
    check("t3_empty", empty, 1);
    tick();
    check("t3_idle", wb_en, 0);

    // address 0 accepted but dropped
    drive_a(1'b1, 5'd0, 32'hFFFF);
    check("t4_a_ready", prod.a_ready, 1);
    tick();
    drive_a(1'b0, '0, '0);
    check("t4_count", count, 0);
    tick();
    check("t4_no_wb", wb_en, 0);
    rd_addr_0 = 5'd0;
    #1 check("t4_pend0_zero", pend_0, 0);

    // two writes to r7, youngest wins forwarding
    wb_hold = 1'b1;
    drive_a(1'b1, 5'd7, 32'h1); tick();
    drive_a(1'b1, 5'd7, 32'h2); tick();
    drive_a(1'b0, '0, '0);
    rd_addr_1 = 5'd7;
    #1 check("t5_pend1", pend_1, 1);
`ifdef WB_QUEUE_BYPASS_EN
    check("t5_byp_hit", byp_hit_1, 1);
    check("t5_byp_data", byp_data_1, 32'h2);
`else
    check("t5_byp_hit_off", byp_hit_1, 0);
    check("t5_byp_data_off", byp_data_1, 0);
`endif
    wb_hold = 1'b0;
    tick();
    check("t5_wb0_data", wb_data, 32'h1);
    tick();
    check("t5_wb1_data", wb_data, 32'h2);
    check("t5_pend_wbstage", pend_1, 1);
`ifdef WB_QUEUE_BYPASS_EN
    check("t5_byp_wbstage", byp_data_1, 32'h2);
`endif
    tick();
    check("t5_pend_clear", pend_1, 0);
    rd_addr_1 = '0;

    // reset mid-drain
    wb_hold = 1'b1;
    drive_a(1'b1, 5'd12, 32'hA); drive_b(1'b1, 5'd13, 32'hB); tick();
    drive_a(1'b1, 5'd14, 32'hC); drive_b(1'b0, '0, '0); tick();
    drive_a(1'b0, '0, '0);
    check("t6_count3", count, 3);
    wb_hold = 1'b0;
    tick();
    check("t6_first_wb", wb_addr, 12);
    rst = 1'b1;
    #1;
    check("t6_rst_wb_en", wb_en, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wb_en) pulses++;
    end
    check("t6_no_writes_after_rst", pulses, 0);
    check("t6_final_count", count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
